// File: rtl/pcs_deskew_pkg.sv
// rtl/pcs_deskew_pkg.sv - shared deskew state encodings and default lane sizes
package pcs_deskew_pkg;

  typedef enum logic [2:0] {
    ST_UNLOCKED = 3'b001,
    ST_LOCKED   = 3'b010,
    ST_ERROR    = 3'b100
  } deskew_state_t;

  localparam int MAX_SKEW = 16;
  localparam int NB_BLOCK = 66;

endpackage

// File: rtl/lane_deskew_fifo_if.sv
// rtl/lane_deskew_fifo_if.sv - lane deskew block stream and control bundle
// o_skew_err exists only when LANE_DESKEW_ERR_EN is defined
interface lane_deskew_fifo_if #(
  parameter int NB_DATA  = pcs_deskew_pkg::NB_BLOCK,
  parameter int NB_COUNT = $clog2(pcs_deskew_pkg::MAX_SKEW) + 1,
  parameter int NB_DELAY = $clog2(pcs_deskew_pkg::MAX_SKEW)
);
  logic                i_enable;
  logic                i_resync;
  logic                i_set_delay;
  logic [NB_COUNT-1:0] i_lane_skew;
  logic [NB_DATA-1:0]  i_data;
  logic [NB_DATA-1:0]  o_data;
  logic                o_valid;
  logic [NB_DELAY-1:0] o_delay;
`ifdef LANE_DESKEW_ERR_EN
  logic                o_skew_err;
`endif

  modport master (
    output i_enable, i_resync, i_set_delay, i_lane_skew, i_data,
`ifdef LANE_DESKEW_ERR_EN
    input  o_skew_err,
`endif
    input  o_data, o_valid, o_delay
  );

  modport slave (
    input  i_enable, i_resync, i_set_delay, i_lane_skew, i_data,
`ifdef LANE_DESKEW_ERR_EN
    output o_skew_err,
`endif
    output o_data, o_valid, o_delay
  );

endinterface

// File: rtl/deskew_ram.sv
// rtl/deskew_ram.sv - simple dual-port RAM, synchronous write, asynchronous read
module deskew_ram #(
  parameter int   NB_DATA = 66,
  parameter int   DEPTH   = 16,
  localparam int  NB_ADDR = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lane_deskew_fifo.sv
// rtl/lane_deskew_fifo.sv - per-lane programmable delay line for PCS deskew
// LANE_DESKEW_ERR_EN adds the ERROR state and o_skew_err; otherwise bad skew is clamped
module lane_deskew_fifo #(
  parameter int NB_DATA  = pcs_deskew_pkg::NB_BLOCK,
  parameter int MAX_SKEW = pcs_deskew_pkg::MAX_SKEW
) (
  input  logic              i_clock,
  input  logic              i_reset,
  lane_deskew_fifo_if.slave bus
);
  import pcs_deskew_pkg::*;

  localparam int DEPTH    = MAX_SKEW;
  localparam int NB_PTR   = $clog2(DEPTH);
  localparam int NB_COUNT = NB_PTR + 1;

  deskew_state_t       state;
  logic [NB_PTR-1:0]   wr_ptr;
  logic [NB_PTR-1:0]   delay;
  logic [NB_PTR-1:0]   rd_addr;
  logic [NB_PTR-1:0]   cap_delay;
  logic [NB_COUNT-1:0] fill;
  logic [NB_COUNT-1:0] fill_next;
  logic [NB_DATA-1:0]  rd_data;
  logic [NB_DATA-1:0]  data_q;
  logic                valid_q;
  logic                skew_ok;
`ifdef LANE_DESKEW_ERR_EN
  logic                skew_err_q;
`endif

  // Pointer subtraction wraps modulo DEPTH, so wr_ptr < delay needs no special case
  assign rd_addr   = wr_ptr - delay;
  assign fill_next = (fill == NB_COUNT'(DEPTH)) ? fill : fill + 1'b1;
  assign skew_ok   = bus.i_lane_skew < NB_COUNT'(MAX_SKEW);
  assign cap_delay = skew_ok ? bus.i_lane_skew[NB_PTR-1:0] : {NB_PTR{1'b1}};

  deskew_ram #(
    .NB_DATA (NB_DATA),
    .DEPTH   (DEPTH)
  ) u_ram (
    .clock   (i_clock),
    .wr_en   (bus.i_enable),
    .wr_addr (wr_ptr),
    .wr_data (bus.i_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // fill survives resync: the RAM keeps valid history across re-alignment
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      fill   <= '0;
      data_q <= '0;
    end else if (bus.i_enable) begin
      wr_ptr <= wr_ptr + 1'b1;
      fill   <= fill_next;
      data_q <= (delay == '0) ? bus.i_data : rd_data;
    end
  end

  // o_valid looks ahead at fill_next and the delay about to be applied
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_UNLOCKED;
      delay      <= '0;
      valid_q    <= 1'b0;
`ifdef LANE_DESKEW_ERR_EN
      skew_err_q <= 1'b0;
`endif
    end else if (bus.i_enable) begin
      if (bus.i_resync) begin
        state      <= ST_UNLOCKED;
        delay      <= '0;
        valid_q    <= 1'b0;
`ifdef LANE_DESKEW_ERR_EN
        skew_err_q <= 1'b0;
`endif
      end else if (bus.i_set_delay && state != ST_ERROR) begin
`ifdef LANE_DESKEW_ERR_EN
        if (!skew_ok) begin
          state      <= ST_ERROR;
          valid_q    <= 1'b0;
          skew_err_q <= 1'b1;
        end else
`endif
        begin
          state   <= ST_LOCKED;
          delay   <= cap_delay;
          valid_q <= fill_next > {1'b0, cap_delay};
        end
      end else begin
        valid_q <= (state == ST_LOCKED) && (fill_next > {1'b0, delay});
      end
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_delay    = delay;
`ifdef LANE_DESKEW_ERR_EN
  assign bus.o_skew_err = skew_err_q;
`endif

endmodule

// File: tb/tb_lane_deskew_fifo.sv
// tb/tb_lane_deskew_fifo.sv - randomized self-checking bench for lane_deskew_fifo
// Reference model: output block is the one written delay enable-cycles earlier
module tb_lane_deskew_fifo;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  lane_deskew_fifo_if #(.NB_DATA(66), .NB_COUNT(5), .NB_DELAY(4)) bus ();

  lane_deskew_fifo #(.NB_DATA(66), .MAX_SKEW(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  logic [65:0] hist [$];
  int          m_fill;
  int          m_delay;
  bit          m_locked;
  bit          m_err;
  logic [65:0] exp_data;
  bit          exp_known;
  bit          exp_valid;

  function automatic logic [65:0] rnd66();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[65:0];
  endfunction

  task automatic drive(input bit en, input bit rs, input bit sd, input int skew,
                       input logic [65:0] d);
    int idx;
    bus.i_enable    = en;
    bus.i_resync    = rs;
    bus.i_set_delay = sd;
    bus.i_lane_skew = 5'(skew);
    bus.i_data      = d;
    @(posedge clk);
    #1;
    if (en) begin
      hist.push_back(d);
      m_fill++;
      idx = hist.size() - 1 - m_delay;
      exp_known = (idx >= 0);
      if (exp_known) exp_data = hist[idx];
      if (rs) begin
        m_locked = 0;
        m_err    = 0;
        m_delay  = 0;
      end else if (sd && !m_err) begin
        if (skew < 16) begin
          m_locked = 1;
          m_delay  = skew;
        end else begin
`ifdef LANE_DESKEW_ERR_EN
          m_err    = 1;
          m_locked = 0;
`else
          m_locked = 1;
          m_delay  = 15;
`endif
        end
      end
      exp_valid = m_locked && (m_fill > m_delay);
    end
    bus.i_enable    = 1'b0;
    bus.i_resync    = 1'b0;
    bus.i_set_delay = 1'b0;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.i_enable    = 1'b0;
    bus.i_resync    = 1'b0;
    bus.i_set_delay = 1'b0;
    bus.i_lane_skew = '0;
    bus.i_data      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    m_fill    = 0;
    m_delay   = 0;
    m_locked  = 0;
    m_err     = 0;
    exp_data  = '0;
    exp_known = 1;
    exp_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
    end
    checks++;
    if (bus.o_delay !== 4'd0) begin
      errors++; $display("FAIL reset_delay: got %0d expected 0", bus.o_delay);
    end
    checks++;
    if (bus.o_data !== 66'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", bus.o_data);
    end
`ifdef LANE_DESKEW_ERR_EN
    checks++;
    if (bus.o_skew_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b expected 0", bus.o_skew_err);
    end
`endif
  endtask

  task automatic test_unlocked();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 66'(i + 1));
      checks++;
      if (bus.o_data !== 66'(i + 1)) begin
        errors++; $display("FAIL unlocked_data[%0d]: got %h expected %h", i, bus.o_data, 66'(i + 1));
      end
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_delay !== 4'd0) begin
        errors++; $display("FAIL unlocked_ctrl[%0d]: got valid=%b delay=%0d expected valid=0 delay=0",
                           i, bus.o_valid, bus.o_delay);
      end
    end
  endtask

  task automatic test_lock5();
    drive(1, 0, 1, 5, rnd66());
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_delay !== 4'd5) begin
      errors++; $display("FAIL lock5_strobe: got valid=%b delay=%0d expected valid=1 delay=5",
                         bus.o_valid, bus.o_delay);
    end
    for (int i = 0; i < 48; i++) begin
      drive(1, 0, 0, 0, rnd66());
      checks++;
      if (!exp_known || bus.o_data !== exp_data || bus.o_valid !== 1'b1) begin
        errors++; $display("FAIL lock5_data[%0d]: got %h/%b expected %h/1 known=%0d",
                           i, bus.o_data, bus.o_valid, exp_data, exp_known);
      end
    end
  endtask

  task automatic test_partial_fill();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, rnd66());
    drive(1, 0, 1, 5, rnd66());
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_valid !== exp_valid) begin
        errors++; $display("FAIL partial_valid[fill=%0d]: got %b expected %b", m_fill, bus.o_valid, exp_valid);
      end
      if (exp_known) begin
        checks++;
        if (bus.o_data !== exp_data) begin
          errors++; $display("FAIL partial_data[fill=%0d]: got %h expected %h", m_fill, bus.o_data, exp_data);
        end
      end
      drive(1, 0, 0, 0, rnd66());
    end
    checks++;
    if (bus.o_valid !== 1'b1 || m_fill != 8) begin
      errors++; $display("FAIL partial_final: got valid=%b fill=%0d expected valid=1 fill=8", bus.o_valid, m_fill);
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 12; i++) drive(1, 0, 0, 0, rnd66());
    drive(1, 0, 1, 15, rnd66());
    checks++;
    if (bus.o_delay !== 4'd15) begin
      errors++; $display("FAIL rnd_delay: got %0d expected 15", bus.o_delay);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 0, 0, 0, rnd66());
      checks++;
      if (bus.o_valid !== exp_valid) begin
        errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, bus.o_valid, exp_valid);
      end
      if (exp_known) begin
        checks++;
        if (bus.o_data !== exp_data) begin
          errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, bus.o_data, exp_data);
        end
      end
    end
  endtask

  task automatic test_skew16();
    drive(1, 0, 1, 16, rnd66());
`ifdef LANE_DESKEW_ERR_EN
    checks++;
    if (bus.o_skew_err !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL skew16_err: got err=%b valid=%b expected err=1 valid=0", bus.o_skew_err, bus.o_valid);
    end
    drive(1, 0, 1, 3, rnd66());
    checks++;
    if (bus.o_skew_err !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL skew16_sticky: got err=%b valid=%b expected err=1 valid=0", bus.o_skew_err, bus.o_valid);
    end
    drive(1, 1, 0, 0, rnd66());
    checks++;
    if (bus.o_skew_err !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_delay !== 4'd0) begin
      errors++; $display("FAIL skew16_resync: got err=%b valid=%b delay=%0d expected err=0 valid=0 delay=0",
                         bus.o_skew_err, bus.o_valid, bus.o_delay);
    end
`else
    checks++;
    if (bus.o_delay !== 4'd15 || bus.o_valid !== 1'b1) begin
      errors++; $display("FAIL skew16_clamp: got delay=%0d valid=%b expected delay=15 valid=1", bus.o_delay, bus.o_valid);
    end
`endif
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, rnd66());
      checks++;
      if (bus.o_data !== exp_data || bus.o_valid !== exp_valid) begin
        errors++; $display("FAIL skew16_data[%0d]: got %h/%b expected %h/%b", i, bus.o_data, bus.o_valid, exp_data, exp_valid);
      end
    end
  endtask

  task automatic test_resync_strobe();
    drive(1, 0, 1, 7, rnd66());
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, rnd66());
    checks++;
    if (bus.o_delay !== 4'd7 || bus.o_valid !== 1'b1) begin
      errors++; $display("FAIL rs_locked7: got delay=%0d valid=%b expected delay=7 valid=1", bus.o_delay, bus.o_valid);
    end
    drive(1, 1, 1, 3, rnd66());
    checks++;
    if (bus.o_delay !== 4'd0 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL rs_collide: got delay=%0d valid=%b expected delay=0 valid=0", bus.o_delay, bus.o_valid);
    end
    drive(1, 0, 0, 0, rnd66());
    checks++;
    if (bus.o_data !== exp_data || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL rs_unlocked: got %h/%b expected %h/0", bus.o_data, bus.o_valid, exp_data);
    end
    drive(1, 0, 1, 2, rnd66());
    checks++;
    if (bus.o_delay !== 4'd2 || bus.o_valid !== 1'b1) begin
      errors++; $display("FAIL rs_relock2: got delay=%0d valid=%b expected delay=2 valid=1", bus.o_delay, bus.o_valid);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, rnd66());
      checks++;
      if (bus.o_data !== exp_data || bus.o_valid !== 1'b1) begin
        errors++; $display("FAIL rs_data[%0d]: got %h/%b expected %h/1", i, bus.o_data, bus.o_valid, exp_data);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    test_reset();
    test_unlocked();
    test_lock5();
    test_partial_fill();
    test_random_enable();
    test_skew16();
    test_resync_strobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
